// File: rtl/stream_rsort.sv
// stream_rsort: streaming descending sorter for unsigned words.
//   Collects N words from a valid/ready input stream, sorts them in place
//   with N odd-even transposition passes (one pass per cycle, built from
//   rsort2 compare-swap cells), then streams them out largest-first.
//   Batches do not overlap: load, sort and drain run back to back.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   in_data valid
//   in_ready   block accepts in_data this cycle (0 while rst=1)
//   in_data    unsigned word to sort
//   out_valid  out_data valid
//   out_ready  consumer accepts out_data this cycle
//   out_data   sorted word, descending order
//   out_last   marks the Nth (smallest) output word
//   busy       high while sorting or draining

// rsort2: two-input compare-swap cell, larger value on hi, smaller on lo.
module rsort2 #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);
  assign hi = (a < b) ? b : a;
  assign lo = (a < b) ? a : b;
endmodule

module stream_rsort #(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

  state_t                  state;
  logic [CW-1:0]           wr;
  logic [CW-1:0]           pass;
  logic [CW-1:0]           rd;
  logic                    in_ready_q;
  logic [DATA_WIDTH-1:0]   slot        [N];
  logic [DATA_WIDTH-1:0]   pass_result [N];
  logic [DATA_WIDTH-1:0]   hi          [N-1];
  logic [DATA_WIDTH-1:0]   lo          [N-1];

  // One compare-swap cell per adjacent pair; each pass only uses the
  // cells whose lower index has the same parity as the pass number.
  for (genvar g = 0; g < N - 1; g++) begin : g_cell
    rsort2 #(.W(DATA_WIDTH)) u_cell (
      .a (slot[g]),
      .b (slot[g+1]),
      .hi(hi[g]),
      .lo(lo[g])
    );
  end

  // Even passes touch pairs (0,1),(2,3)..; odd passes touch (1,2),(3,4)..
  // so the end slots are left alone on odd passes.
  always_comb begin
    pass_result = slot;
    for (int i = 0; i < N - 1; i++) begin
      if (i[0] == pass[0]) begin
        pass_result[i]   = hi[i];
        pass_result[i+1] = lo[i];
      end
    end
  end

  // in_ready is registered but masked by rst so it drops in the reset cycle.
  assign in_ready = in_ready_q & ~rst;
  assign out_data = slot[rd];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOAD;
      wr         <= '0;
      pass       <= '0;
      rd         <= '0;
      in_ready_q <= 1'b1;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            slot[wr] <= in_data;
            if (wr == LAST) begin
              state      <= SORT;
              wr         <= '0;
              pass       <= '0;
              in_ready_q <= 1'b0;
              busy       <= 1'b1;
            end else begin
              wr <= wr + 1'b1;
            end
          end
        end
        SORT: begin
          slot <= pass_result;
          pass <= pass + 1'b1;
          if (pass == LAST) begin
            state     <= DRAIN;
            rd        <= '0;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (rd == LAST) begin
              state      <= LOAD;
              rd         <= '0;
              out_valid  <= 1'b0;
              out_last   <= 1'b0;
              busy       <= 1'b0;
              in_ready_q <= 1'b1;
            end else begin
              rd       <= rd + 1'b1;
              out_last <= ((rd + 1'b1) == LAST);
            end
          end
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

endmodule
